// File: rtl/regbank_decode.sv
// Banked register address decode with a call/return bank stack.
// Optional macro REGBANK_SP_OUT_EN exposes the registered stack pointer as stack_ptr.
module regbank_decode #(
  parameter int BANK_W      = 2,
  parameter int FIELD_W     = 2,
  parameter int NPORTS      = 2,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int ADDR_W     = BANK_W + FIELD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [BANK_W-1:0]        set_bank,
  input  logic                     push,
  input  logic                     pop,
  input  logic [NPORTS*FIELD_W-1:0] fields,
  output logic [NPORTS*ADDR_W-1:0] reg_addr,
  output logic [BANK_W-1:0]        cur_bank,
  output logic                     stack_full,
  output logic                     stack_empty,
`ifdef REGBANK_SP_OUT_EN
  output logic [SP_W-1:0]          stack_ptr,
`endif
  output logic                     stack_err
);

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  logic [BANK_W-1:0]        bank_q, bank_d;
  logic [SP_W-1:0]          sp_q, sp_d;
  logic                     err_q, err_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic [NPORTS*ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [BANK_W-1:0]        stack_q [STACK_DEPTH];
  logic [BANK_W-1:0]        stack_d [STACK_DEPTH];
  logic [BANK_W-1:0]        stack_top_s;
  logic                     is_full_s;
  logic                     is_empty_s;

  assign is_full_s  = (sp_q == SP_FULL);
  assign is_empty_s = (sp_q == SP_ZERO);

  // Select the entry at sp-1 without indexing the array by the wider pointer
  always_comb begin
    stack_top_s = {BANK_W{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_top_s = (sp_q == SP_W'(i + 1)) ? stack_q[i] : stack_top_s;
    end
  end

  // Prioritised bank/stack update and same-cycle address formation
  always_comb begin
    bank_d  = bank_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (push && pop) begin
      err_d = 1'b1;
    end else if (push && is_full_s) begin
      err_d = 1'b1;
    end else if (push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_d[i] = (sp_q == SP_W'(i)) ? bank_q : stack_q[i];
      end
      sp_d   = sp_q + SP_ONE;
      bank_d = set_bank;
    end else if (pop && is_empty_s) begin
      err_d = 1'b1;
    end else if (pop) begin
      sp_d   = sp_q - SP_ONE;
      bank_d = stack_top_s;
    end else if (set_en) begin
      bank_d = set_bank;
    end else begin
      bank_d = bank_q;
    end

    full_d  = (sp_d == SP_FULL);
    empty_d = (sp_d == SP_ZERO);

    reg_addr_d = {(NPORTS*ADDR_W){1'b0}};
    for (int i = 0; i < NPORTS; i++) begin
      reg_addr_d[i*ADDR_W +: ADDR_W] = {bank_d, fields[i*FIELD_W +: FIELD_W]};
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q     <= {BANK_W{1'b0}};
      sp_q       <= SP_ZERO;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      reg_addr_q <= {(NPORTS*ADDR_W){1'b0}};
    end else begin
      bank_q     <= bank_d;
      sp_q       <= sp_d;
      err_q      <= err_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  // Stack storage; contents are don't-care after reset since sp guards every read
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign reg_addr    = reg_addr_q;
  assign cur_bank    = bank_q;
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign stack_err   = err_q;
`ifdef REGBANK_SP_OUT_EN
  assign stack_ptr   = sp_q;
`endif

endmodule

// File: tb/tb_regbank_decode.sv
// Randomised and directed bench for regbank_decode against a queue-based bank stack model.
module tb_regbank_decode;

  localparam int BANK_W  = 2;
  localparam int FIELD_W = 2;
  localparam int NPORTS  = 2;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = BANK_W + FIELD_W;
  localparam int SP_W    = $clog2(DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      set_en;
  logic [BANK_W-1:0]         set_bank;
  logic                      push;
  logic                      pop;
  logic [NPORTS*FIELD_W-1:0] fields;
  logic [NPORTS*ADDR_W-1:0]  reg_addr;
  logic [BANK_W-1:0]         cur_bank;
  logic                      stack_full;
  logic                      stack_empty;
  logic                      stack_err;
`ifdef REGBANK_SP_OUT_EN
  logic [SP_W-1:0]           stack_ptr;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int                       m_bank;
  int                       m_stk[$];
  bit                       m_err;
  logic [NPORTS*ADDR_W-1:0] m_addr;

  regbank_decode #(
    .BANK_W(BANK_W), .FIELD_W(FIELD_W), .NPORTS(NPORTS), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .set_en(set_en), .set_bank(set_bank),
    .push(push), .pop(pop), .fields(fields), .reg_addr(reg_addr),
    .cur_bank(cur_bank), .stack_full(stack_full), .stack_empty(stack_empty),
`ifdef REGBANK_SP_OUT_EN
    .stack_ptr(stack_ptr),
`endif
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare every output
  task automatic apply(input bit rst, input bit se, input int sb, input bit pu, input bit po,
                       input logic [NPORTS*FIELD_W-1:0] f);
    int         nb;
    logic [1:0] nbl;
    reset = rst; set_en = se; set_bank = BANK_W'(sb); push = pu; pop = po; fields = f;
    @(posedge clk);
    if (rst) begin
      m_bank = 0;
      m_stk.delete();
      m_err  = 1'b0;
      m_addr = '0;
    end else begin
      nb = m_bank;
      if (pu && po)                   m_err = 1'b1;
      else if (pu && m_stk.size() == DEPTH) m_err = 1'b1;
      else if (pu) begin m_stk.push_back(m_bank); nb = sb; end
      else if (po && m_stk.size() == 0) m_err = 1'b1;
      else if (po)                    nb = m_stk.pop_back();
      else if (se)                    nb = sb;
      m_bank = nb;
      nbl = nb[1:0];
      for (int i = 0; i < NPORTS; i++) m_addr[i*ADDR_W +: ADDR_W] = {nbl, f[i*FIELD_W +: FIELD_W]};
    end
    #1;
    check_eq("reg_addr",    32'(reg_addr),    32'(m_addr));
    check_eq("cur_bank",    32'(cur_bank),    32'(m_bank));
    check_eq("stack_full",  32'(stack_full),  32'(m_stk.size() == DEPTH));
    check_eq("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    check_eq("stack_err",   32'(stack_err),   32'(m_err));
`ifdef REGBANK_SP_OUT_EN
    check_eq("stack_ptr",   32'(stack_ptr),   32'(m_stk.size()));
`endif
  endtask

  initial begin
    int r;
    m_bank = 0; m_err = 1'b0; m_addr = '0;

    // Reset then plain decode
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b1101);
    check_eq("tp_rst_addr", 32'(reg_addr), 32'h0);
    check_eq("tp_rst_empty", 32'(stack_empty), 32'h1);
    apply(1'b0, 1'b0, 0, 1'b0, 1'b0, 4'b1101);
    check_eq("tp_plain_addr", 32'(reg_addr), 32'h31);

    // Set bank with same-cycle bypass, then hold
    apply(1'b0, 1'b1, 2, 1'b0, 1'b0, 4'b0010);
    check_eq("tp_set_addr", 32'(reg_addr), 32'h8A);
    apply(1'b0, 1'b0, 0, 1'b0, 1'b0, 4'b0000);
    check_eq("tp_set_hold", 32'(cur_bank), 32'h2);

    // Nested calls
    apply(1'b0, 1'b1, 1, 1'b0, 1'b0, 4'b0000);
    check_eq("tp_nest0", 32'(cur_bank), 32'h1);
    apply(1'b0, 1'b0, 2, 1'b1, 1'b0, 4'b0000);
    check_eq("tp_nest1", 32'(cur_bank), 32'h2);
    apply(1'b0, 1'b0, 3, 1'b1, 1'b0, 4'b0000);
    check_eq("tp_nest2", 32'(cur_bank), 32'h3);
    apply(1'b0, 1'b1, 0, 1'b0, 1'b1, 4'b0000);
    check_eq("tp_nest3", 32'(cur_bank), 32'h2);
    apply(1'b0, 1'b0, 0, 1'b0, 1'b1, 4'b0000);
    check_eq("tp_nest4", 32'(cur_bank), 32'h1);
    check_eq("tp_nest_err", 32'(stack_err), 32'h0);

    // Overflow
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 2, 1'b1, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 3, 1'b1, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 1, 1'b1, 1'b0, 4'b0000);
    check_eq("tp_ovf_full", 32'(stack_full), 32'h1);
    apply(1'b0, 1'b0, 3, 1'b1, 1'b0, 4'b0110);
    check_eq("tp_ovf_err", 32'(stack_err), 32'h1);
    check_eq("tp_ovf_bank", 32'(cur_bank), 32'h1);
    check_eq("tp_ovf_addr", 32'(reg_addr), 32'h5_6);
    apply(1'b0, 1'b0, 0, 1'b0, 1'b1, 4'b0000);
    check_eq("tp_ovf_pop", 32'(cur_bank), 32'h3);

    // Underflow and illegal op
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 0, 1'b0, 1'b1, 4'b0000);
    check_eq("tp_udf_err", 32'(stack_err), 32'h1);
    check_eq("tp_udf_bank", 32'(cur_bank), 32'h0);
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000);
    apply(1'b0, 1'b1, 2, 1'b1, 1'b1, 4'b0000);
    check_eq("tp_ill_err", 32'(stack_err), 32'h1);
    check_eq("tp_ill_bank", 32'(cur_bank), 32'h0);

    // Reset mid-operation wins over pop
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 2, 1'b1, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 3, 1'b1, 1'b0, 4'b1111);
    apply(1'b1, 1'b0, 0, 1'b0, 1'b1, 4'b1111);
    check_eq("tp_mid_bank", 32'(cur_bank), 32'h0);
    check_eq("tp_mid_addr", 32'(reg_addr), 32'h0);
    check_eq("tp_mid_err", 32'(stack_err), 32'h0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 63));
      if (r == 0)
        apply(1'b1, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 4'($urandom));
      else if (r < 22)
        apply(1'b0, 1'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0, 4'($urandom));
      else if (r < 42)
        apply(1'b0, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b1, 4'($urandom));
      else if (r < 44)
        apply(1'b0, 1'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b1, 4'($urandom));
      else
        apply(1'b0, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
